up_counter_4bit: RTL and testbench



---
 rtl/up_counter_4bit.sv | 28 ++
 tb/tb_up_counter_4bit.sv | 118 +++++++++++
 2 files changed

// File: rtl/up_counter_4bit.sv
// Loadable binary up-counter with asynchronous active-high clear.
// The count wraps modulo 2^WIDTH and c_out comes straight from the state register.
module up_counter_4bit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d_in,
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  output logic [WIDTH-1:0] c_out
);

  logic [WIDTH-1:0] count;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= d_in;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign c_out = count;

endmodule

// File: tb/tb_up_counter_4bit.sv
// Directed bench for up_counter_4bit: a vector table plus hand-written
// sequences for the asynchronous reset and the reset-versus-load cases.
module tb_up_counter_4bit;

  localparam int WIDTH = 4;

  logic [WIDTH-1:0] d_in;
  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] c_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] exp;
  } vec_t;

  up_counter_4bit #(.WIDTH(WIDTH)) dut (
    .d_in  (d_in),
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives on the falling edge, checks 1 ns after the following rising edge.
  task automatic step(input string name, input logic r, input logic l,
                      input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp);
    @(negedge clk);
    rst  = r;
    load = l;
    d_in = d;
    @(posedge clk);
    #1;
    check(name, c_out, exp);
  endtask

  vec_t vecs[20];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 4'h0};
    vecs[1]  = '{1'b0, 1'b0, 4'h0, 4'h1};
    vecs[2]  = '{1'b0, 1'b0, 4'h0, 4'h2};
    vecs[3]  = '{1'b0, 1'b0, 4'h0, 4'h3};
    vecs[4]  = '{1'b0, 1'b1, 4'h6, 4'h6};
    vecs[5]  = '{1'b0, 1'b0, 4'h6, 4'h7};
    vecs[6]  = '{1'b0, 1'b0, 4'h0, 4'h8};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 4'h9};
    vecs[8]  = '{1'b0, 1'b1, 4'hE, 4'hE};
    vecs[9]  = '{1'b0, 1'b0, 4'h0, 4'hF};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 4'h0};
    vecs[11] = '{1'b0, 1'b0, 4'h0, 4'h1};
    vecs[12] = '{1'b0, 1'b1, 4'h5, 4'h5};
    vecs[13] = '{1'b0, 1'b1, 4'h5, 4'h5};
    vecs[14] = '{1'b0, 1'b1, 4'h5, 4'h5};
    vecs[15] = '{1'b0, 1'b0, 4'hA, 4'h6};
    vecs[16] = '{1'b0, 1'b0, 4'hC, 4'h7};
    vecs[17] = '{1'b0, 1'b1, 4'hF, 4'hF};
    vecs[18] = '{1'b0, 1'b1, 4'h3, 4'h3};
    vecs[19] = '{1'b0, 1'b0, 4'h9, 4'h4};

    rst  = 1'b1;
    load = 1'b0;
    d_in = '0;
    #1;
    check("async_reset_at_start", c_out, 4'h0);

    for (int i = 0; i < 20; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].load, vecs[i].d_in, vecs[i].exp);
    end

    // Async reset mid-count: clear must appear well before the next rising edge.
    step("load_9", 1'b0, 1'b1, 4'h9, 4'h9);
    @(negedge clk);
    load = 1'b0;
    rst  = 1'b1;
    #1;
    check("async_clear_between_edges", c_out, 4'h0);
    @(posedge clk);
    #1;
    check("reset_holds_zero", c_out, 4'h0);

    // Reset beats load, then load takes effect on the first edge after release.
    step("reset_beats_load", 1'b1, 1'b1, 4'hC, 4'h0);
    step("load_after_reset", 1'b0, 1'b1, 4'hC, 4'hC);
    step("count_after_load", 1'b0, 1'b0, 4'hC, 4'hD);
    step("count_e", 1'b0, 1'b0, 4'h0, 4'hE);
    step("count_f", 1'b0, 1'b0, 4'h0, 4'hF);
    step("wrap_to_zero", 1'b0, 1'b0, 4'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog timeout");
  end

endmodule
